// File: rtl/calc_pkg.sv
// Shared types and constants for the finger calculator.
package calc_pkg;

    // Operation sequencer states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LATCH = 2'd1,
        APPLY = 2'd2,
        HOLD  = 2'd3
    } calc_state_t;

    // Active-low hex font, bit order {g,f,e,d,c,b,a}.
    localparam logic [6:0] HEX_FONT [16] = '{
        7'b1000000,  // 0
        7'b1111001,  // 1
        7'b0100100,  // 2
        7'b0110000,  // 3
        7'b0011001,  // 4
        7'b0010010,  // 5
        7'b0000010,  // 6
        7'b1111000,  // 7
        7'b0000000,  // 8
        7'b0010000,  // 9
        7'b0001000,  // A
        7'b0000011,  // b
        7'b1000110,  // C
        7'b0100001,  // d
        7'b0000110,  // E
        7'b0001110   // F
    };

endpackage

// File: rtl/finger_calc_accum_hex_to_7seg.sv
// Hex nibble to active-low 7-segment pattern.
module hex_to_7seg
    import calc_pkg::*;
(
    input  logic [3:0] nibble_i,
    output logic [6:0] seg_o
);

    assign seg_o = HEX_FONT[nibble_i];

endmodule

// File: rtl/finger_calc_accum.sv
// Finger-count accumulator: synchronisers, enter debouncer, operation
// sequencer, wide accumulator with sticky overflow, multiplexed hex display.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for a debounced enter press
// LATCH | capture operand (finger count) and add/subtract mode
// APPLY | update accumulator and overflow, pulse done
// HOLD  | wait for debounced enter release before accepting a new press
module finger_calc_accum
    import calc_pkg::*;
#(
    parameter int N_FINGERS   = 4,
    parameter int ACC_W       = 8,
    parameter int DEB_CYCLES  = 16,
    parameter int N_DIGITS    = 2,
    parameter int REFRESH_DIV = 1024
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N_FINGERS-1:0] fingers,
    input  logic                 enter,
    input  logic                 mode,
    input  logic                 clear,
    output logic [ACC_W-1:0]     acc,
    output logic                 ovf,
    output logic                 done,
    output logic [N_DIGITS-1:0]  an,
    output logic [6:0]           seg
);

    localparam int OP_W  = $clog2(N_FINGERS + 1);
    localparam int DEB_W = $clog2(DEB_CYCLES);
    localparam int REF_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam int PAD_W = 4 * N_DIGITS;

    localparam logic [DEB_W-1:0] DEB_RELOAD = DEB_W'(DEB_CYCLES - 1);
    localparam logic [REF_W-1:0] REF_RELOAD = REF_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(N_DIGITS - 1);

    // ------------------------------------------------------------------
    // Input synchronisers
    // ------------------------------------------------------------------
    logic [N_FINGERS-1:0] fingers_s1_q, fingers_s2_q;
    logic                 enter_s1_q, enter_s2_q;
    logic                 mode_s1_q, mode_s2_q;
    logic                 clear_s1_q, clear_s2_q;

    // Two-flop synchronisers for all raw board inputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fingers_s1_q <= '0;
            fingers_s2_q <= '0;
            enter_s1_q   <= 1'b0;
            enter_s2_q   <= 1'b0;
            mode_s1_q    <= 1'b0;
            mode_s2_q    <= 1'b0;
            clear_s1_q   <= 1'b0;
            clear_s2_q   <= 1'b0;
        end else begin
            fingers_s1_q <= fingers;
            fingers_s2_q <= fingers_s1_q;
            enter_s1_q   <= enter;
            enter_s2_q   <= enter_s1_q;
            mode_s1_q    <= mode;
            mode_s2_q    <= mode_s1_q;
            clear_s1_q   <= clear;
            clear_s2_q   <= clear_s1_q;
        end
    end

    // Operand is the number of raised fingers.
    logic [OP_W-1:0] finger_cnt;

    // Population count of the synchronised finger switches.
    always_comb begin
        finger_cnt = '0;
        for (int i = 0; i < N_FINGERS; i++) begin
            finger_cnt = finger_cnt + OP_W'(fingers_s2_q[i]);
        end
    end

    // ------------------------------------------------------------------
    // Enter debouncer
    // ------------------------------------------------------------------
    logic [DEB_W-1:0] deb_cnt_q, deb_cnt_d;
    logic             enter_db_q, enter_db_d;
    logic             enter_db_prev_q;

    // Down-counter of consecutive disagreeing cycles; terminal count toggles.
    always_comb begin
        deb_cnt_d  = deb_cnt_q;
        enter_db_d = enter_db_q;
        if (enter_s2_q == enter_db_q) begin
            deb_cnt_d = DEB_RELOAD;
        end else if (deb_cnt_q == '0) begin
            enter_db_d = ~enter_db_q;
            deb_cnt_d  = DEB_RELOAD;
        end else begin
            deb_cnt_d = deb_cnt_q - 1'b1;
        end
    end

    // Debouncer state and previous debounced level for edge detection.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            deb_cnt_q       <= DEB_RELOAD;
            enter_db_q      <= 1'b0;
            enter_db_prev_q <= 1'b0;
        end else begin
            deb_cnt_q       <= deb_cnt_d;
            enter_db_q      <= enter_db_d;
            enter_db_prev_q <= enter_db_q;
        end
    end

    wire enter_rise = enter_db_q & ~enter_db_prev_q;

    // ------------------------------------------------------------------
    // Operation sequencer and accumulator
    // ------------------------------------------------------------------
    calc_state_t      state_q, state_d;
    logic [OP_W-1:0]  op_q, op_d;
    logic             sub_q, sub_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic             ovf_q, ovf_d;
    logic             done_q, done_d;

    // One extra bit holds the carry (add) or borrow (subtract).
    logic [ACC_W:0] sum_ext, diff_ext;
    assign sum_ext  = {1'b0, acc_q} + (ACC_W + 1)'(op_q);
    assign diff_ext = {1'b0, acc_q} - (ACC_W + 1)'(op_q);

    // Next-state and datapath updates; clear overrides everything.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        sub_d   = sub_q;
        acc_d   = acc_q;
        ovf_d   = ovf_q;
        done_d  = 1'b0;
        if (clear_s2_q) begin
            acc_d   = '0;
            ovf_d   = 1'b0;
            state_d = HOLD;
        end else begin
            case (state_q)
                IDLE: begin
                    if (enter_rise) state_d = LATCH;
                end
                LATCH: begin
                    op_d    = finger_cnt;
                    sub_d   = mode_s2_q;
                    state_d = APPLY;
                end
                APPLY: begin
                    if (sub_q) begin
                        acc_d = diff_ext[ACC_W-1:0];
                        ovf_d = ovf_q | diff_ext[ACC_W];
                    end else begin
                        acc_d = sum_ext[ACC_W-1:0];
                        ovf_d = ovf_q | sum_ext[ACC_W];
                    end
                    done_d  = 1'b1;
                    state_d = HOLD;
                end
                HOLD: begin
                    if (!enter_db_q) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Sequencer and accumulator registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            op_q    <= '0;
            sub_q   <= 1'b0;
            acc_q   <= '0;
            ovf_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            sub_q   <= sub_d;
            acc_q   <= acc_d;
            ovf_q   <= ovf_d;
            done_q  <= done_d;
        end
    end

    assign acc  = acc_q;
    assign ovf  = ovf_q;
    assign done = done_q;

    // ------------------------------------------------------------------
    // Display multiplexer
    // ------------------------------------------------------------------
    logic [REF_W-1:0] ref_cnt_q, ref_cnt_d;
    logic [IDX_W-1:0] idx_q, idx_d;

    // Refresh down-counter; each terminal count steps to the next digit.
    always_comb begin
        ref_cnt_d = ref_cnt_q - 1'b1;
        idx_d     = idx_q;
        if (ref_cnt_q == '0) begin
            ref_cnt_d = REF_RELOAD;
            if (idx_q == IDX_LAST) idx_d = '0;
            else                   idx_d = idx_q + 1'b1;
        end
    end

    // Refresh counter and digit index registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ref_cnt_q <= REF_RELOAD;
            idx_q     <= '0;
        end else begin
            ref_cnt_q <= ref_cnt_d;
            idx_q     <= idx_d;
        end
    end

    // Digits beyond the accumulator width display as zero.
    logic [PAD_W-1:0] acc_pad;
    logic [3:0]       digit_nib;
    assign acc_pad = PAD_W'(acc_q);

    // Select the nibble for the active digit.
    always_comb begin
        digit_nib = '0;
        for (int d = 0; d < N_DIGITS; d++) begin
            if (idx_q == IDX_W'(d)) digit_nib = acc_pad[4*d +: 4];
        end
    end

    assign an = ~(N_DIGITS'(1) << idx_q);

    hex_to_7seg u_hex_to_7seg (
        .nibble_i (digit_nib),
        .seg_o    (seg)
    );

endmodule

// File: tb/tb_finger_calc_accum.sv
module tb_finger_calc_accum;

    localparam int DEB = 4;
    localparam int REF = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] fingers;
    logic       enter;
    logic       mode;
    logic       clear;
    logic [7:0] acc;
    logic       ovf;
    logic       done;
    logic [1:0] an;
    logic [6:0] seg;

    finger_calc_accum #(
        .N_FINGERS   (4),
        .ACC_W       (8),
        .DEB_CYCLES  (DEB),
        .N_DIGITS    (2),
        .REFRESH_DIV (REF)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .fingers (fingers),
        .enter   (enter),
        .mode    (mode),
        .clear   (clear),
        .acc     (acc),
        .ovf     (ovf),
        .done    (done),
        .an      (an),
        .seg     (seg)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] acc;
        logic       ovf;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_tests = 0;
    int   n_fail = 0;
    int   done_seen = 0;
    int   model_acc = 0;
    logic model_ovf = 1'b0;

    logic [6:0] font [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Reference model: arithmetic on plain integers, wrap mod 256.
    task automatic push_op(input int op, input logic sub);
        int   r;
        exp_t e;
        r = sub ? model_acc - op : model_acc + op;
        if (r < 0 || r > 255) model_ovf = 1'b1;
        model_acc = (r + 256) % 256;
        e.acc = 8'(model_acc);
        e.ovf = model_ovf;
        exp_q.push_back(e);
    endtask

    // Monitor: every done pulse must match the oldest expected result.
    always @(negedge clk) begin
        if (reset === 1'b1 && done === 1'b1) begin
            done_seen++;
            chk("done_expected", int'(exp_q.size() > 0), 1);
            if (exp_q.size() > 0) begin
                mon_e = exp_q.pop_front();
                chk("done_acc", int'(acc), int'(mon_e.acc));
                chk("done_ovf", int'(ovf), int'(mon_e.ovf));
            end
        end
    end

    task automatic press(input logic [3:0] f, input logic m, input int hold);
        @(negedge clk);
        fingers = f;
        mode    = m;
        repeat (3) @(negedge clk);
        if (hold >= DEB) push_op($countones(f), m);
        enter = 1'b1;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if (i == DEB + 6) begin
                fingers = 4'($urandom);
                mode    = 1'($urandom);
            end
        end
        enter = 1'b0;
        repeat (2 * DEB + 8) @(negedge clk);
    endtask

    task automatic pulse_clear();
        @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        repeat (4) @(negedge clk);
        model_acc = 0;
        model_ovf = 1'b0;
    endtask

    task automatic chk_state(input string tag);
        chk({tag, "_acc"}, int'(acc), model_acc);
        chk({tag, "_ovf"}, int'(ovf), int'(model_ovf));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        n_fail++;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        int   d0;
        int   found;
        int   k;
        int   run;
        int   seen_change;
        int   nib;
        logic [1:0] prev_an;

        reset   = 1'b0;
        fingers = '0;
        enter   = 1'b0;
        mode    = 1'b0;
        clear   = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_acc", int'(acc), 0);
        chk("rst_ovf", int'(ovf), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_an", int'(an), 2);
        chk("rst_seg", int'(seg), 7'b1000000);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        chk("post_rst_acc", int'(acc), 0);
        chk("post_rst_ovf", int'(ovf), 0);
        chk("post_rst_done", int'(done), 0);
        chk("post_rst_an", int'(an), 2);
        chk("post_rst_seg", int'(seg), 7'b1000000);

        // First press with latency measurement
        fingers = 4'b1011;
        mode    = 1'b0;
        repeat (3) @(negedge clk);
        push_op(3, 1'b0);
        d0    = done_seen;
        found = 0;
        enter = 1'b1;
        for (k = 0; k < 30; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (done === 1'b1 && found == 0) begin
                chk("done_latency", k, DEB + 4);
                found = 1;
            end
        end
        chk("first_done_seen", found, 1);
        enter = 1'b0;
        repeat (2 * DEB + 8) @(negedge clk);
        chk("single_done", done_seen - d0, 1);
        chk_state("first_press");
        press(4'b1011, 1'b0, 30);
        chk_state("second_press");

        // Short glitches produce nothing
        d0 = done_seen;
        for (int g = 0; g < 5; g++) press(4'b1111, 1'b0, 2);
        chk("glitch_no_done", done_seen - d0, 0);
        chk_state("glitch");

        // Borrow then carry, ovf sticky
        pulse_clear();
        chk_state("clear1");
        press(4'b0001, 1'b1, 12);
        chk_state("borrow");
        press(4'b1111, 1'b0, 12);
        chk_state("sticky");

        // Clear landing while the sequencer is in LATCH
        fingers = 4'b0111;
        mode    = 1'b0;
        repeat (3) @(negedge clk);
        d0    = done_seen;
        enter = 1'b1;
        repeat (5) @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        repeat (24) @(negedge clk);
        enter = 1'b0;
        repeat (2 * DEB + 8) @(negedge clk);
        model_acc = 0;
        model_ovf = 1'b0;
        chk("latch_clear_no_done", done_seen - d0, 0);
        chk_state("latch_clear");
        press(4'b0111, 1'b0, 12);
        chk_state("after_clear");

        // Debounce boundary
        d0 = done_seen;
        press(4'b0011, 1'b0, DEB - 1);
        chk("deb_minus1_no_done", done_seen - d0, 0);
        press(4'b0011, 1'b0, DEB);
        chk("deb_exact_done", done_seen - d0, 1);
        chk_state("deb_exact");

        // Randomised presses
        for (int r = 0; r < 20; r++) begin
            press(4'($urandom), 1'($urandom), int'($urandom_range(1, 30)));
            chk_state("random");
        end

        // Drive accumulator to 0xA7 and check the display multiplex
        pulse_clear();
        while (model_acc != 167) begin
            k = (167 - model_acc > 4) ? 4 : 167 - model_acc;
            press(4'((1 << k) - 1), 1'b0, DEB + 2);
        end
        chk("disp_acc", int'(acc), 167);
        prev_an     = an;
        run         = 0;
        seen_change = 0;
        for (int c = 0; c < 24; c++) begin
            @(negedge clk);
            chk("an_onehot_low", int'(an == 2'b10 || an == 2'b01), 1);
            nib = (an == 2'b10) ? (model_acc % 16) : (model_acc / 16);
            chk("seg_digit", int'(seg), int'(font[nib]));
            if (an != prev_an) begin
                if (seen_change != 0) chk("digit_period", run, REF);
                seen_change = 1;
                run = 1;
            end else begin
                run++;
            end
            prev_an = an;
        end

        repeat (10) @(negedge clk);
        chk("queue_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
